// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM (master) and the datapath/IR (slave).
// Opcode and status flags flow into the FSM; per-state enables and debug state flow out.
interface multicycle_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             PCWrite;
   logic             AdrSrc;
   logic             IRWrite;
   logic             MemWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [2:0]       ImmSrc;
   logic             illegal;
   logic [3:0]       state_o;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, zero, mem_ready,
      output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state_o, instret
   );

   modport slave (
      output op, zero, mem_ready,
      input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state_o, instret
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// RV32I multi-cycle control unit: walks each instruction through fetch/decode/execute/memory/
// writeback states, drives registered datapath enables and counts retired instructions.
module multicycle_control_fsm #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int EXT_OPS       = 1,
   parameter int TRAP_ILLEGAL  = 1,
   parameter int CNT_W         = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   multicycle_control_fsm_if.master  ctrl_io
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      LUI      = 4'd11,
      AUIPC    = 4'd12,
      ILLEGAL  = 4'd15
   } stateT;

   typedef struct packed {
      logic       adrSrc;
      logic       irWrite;
      logic       pcUpdate;
      logic       memWrite;
      logic       regWrite;
      logic       branch;
      logic       illegal;
      logic [1:0] resultSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
   } ctrlT;

   stateT            state_q, state_d;
   ctrlT             ctrl_q;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             memOk;
   logic             fetchGate;
   logic             retire;
   logic [2:0]       immSrc;

   // Moore enables for a state; registering them on the next state keeps outputs glitch-free.
   function automatic ctrlT decodeState(input stateT s);
      ctrlT c;
      c = '0;
      case (s)
         FETCH: begin
            c.irWrite   = 1'b1;
            c.pcUpdate  = 1'b1;
            c.aluSrcB   = 2'b10;
            c.resultSrc = 2'b10;
         end
         DECODE: begin
            c.aluSrcA = 2'b01;
            c.aluSrcB = 2'b01;
         end
         MEMADR: begin
            c.aluSrcA = 2'b10;
            c.aluSrcB = 2'b01;
         end
         MEMREAD:  c.adrSrc = 1'b1;
         MEMWB: begin
            c.resultSrc = 2'b01;
            c.regWrite  = 1'b1;
         end
         MEMWRITE: begin
            c.adrSrc   = 1'b1;
            c.memWrite = 1'b1;
         end
         EXECR: begin
            c.aluSrcA = 2'b10;
            c.aluOp   = 2'b10;
         end
         EXECI: begin
            c.aluSrcA = 2'b10;
            c.aluSrcB = 2'b01;
            c.aluOp   = 2'b10;
         end
         ALUWB:    c.regWrite = 1'b1;
         BEQ: begin
            c.aluSrcA = 2'b10;
            c.aluOp   = 2'b01;
            c.branch  = 1'b1;
         end
         JAL: begin
            c.aluSrcA  = 2'b01;
            c.aluSrcB  = 2'b10;
            c.pcUpdate = 1'b1;
         end
         LUI: begin
            c.aluSrcB = 2'b01;
            c.aluOp   = 2'b11;
         end
         AUIPC: begin
            c.aluSrcA = 2'b01;
            c.aluSrcB = 2'b01;
         end
         ILLEGAL:  c.illegal = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   assign memOk = (MEM_HANDSHAKE == 0) || ctrl_io.mem_ready;

   // Next-state sequencing; memory states stall until the access completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (memOk) state_d = DECODE;
         DECODE: begin
            case (ctrl_io.op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BEQ:            state_d = BEQ;
               OP_JAL:            state_d = JAL;
               OP_LUI: begin
                  if (EXT_OPS != 0) state_d = LUI;
                  else              state_d = ILLEGAL;
               end
               OP_AUIPC: begin
                  if (EXT_OPS != 0) state_d = AUIPC;
                  else              state_d = ILLEGAL;
               end
               default:           state_d = ILLEGAL;
            endcase
         end
         MEMADR: begin
            if (ctrl_io.op == OP_LOAD) state_d = MEMREAD;
            else                       state_d = MEMWRITE;
         end
         MEMREAD:  if (memOk) state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWRITE: if (memOk) state_d = FETCH;
         EXECR:    state_d = ALUWB;
         EXECI:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BEQ:      state_d = FETCH;
         JAL:      state_d = ALUWB;
         LUI:      state_d = ALUWB;
         AUIPC:    state_d = ALUWB;
         ILLEGAL: begin
            if (TRAP_ILLEGAL != 0) state_d = ILLEGAL;
            else                   state_d = FETCH;
         end
         default:  state_d = FETCH;
      endcase
   end

   // Only completed instructions count; leaving ILLEGAL never does.
   always_comb begin
      retire    = (state_d == FETCH) &&
                  (state_q inside {MEMWB, MEMWRITE, ALUWB, BEQ});
      instret_d = retire ? instret_q + 1'b1 : instret_q;
   end

   // Immediate format follows the opcode directly so the extender is ready in DECODE.
   always_comb begin
      immSrc = 3'b000;
      case (ctrl_io.op)
         OP_STORE:        immSrc = 3'b001;
         OP_BEQ:          immSrc = 3'b010;
         OP_JAL:          immSrc = 3'b011;
         OP_LUI, OP_AUIPC: immSrc = 3'b100;
         default:         immSrc = 3'b000;
      endcase
   end

   // State, registered enables and retire counter; reset preloads the FETCH enables.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FETCH;
         ctrl_q    <= decodeState(FETCH);
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= decodeState(state_d);
         instret_q <= instret_d;
      end
   end

   // IR load and PC increment in FETCH wait for the fetch to actually land.
   assign fetchGate = memOk || (state_q != FETCH);

   assign ctrl_io.PCWrite   = ~rst & ((ctrl_q.pcUpdate & fetchGate) |
                                      (ctrl_q.branch & ctrl_io.zero));
   assign ctrl_io.AdrSrc    = ~rst & ctrl_q.adrSrc;
   assign ctrl_io.IRWrite   = ~rst & ctrl_q.irWrite & fetchGate;
   assign ctrl_io.MemWrite  = ~rst & ctrl_q.memWrite;
   assign ctrl_io.RegWrite  = ~rst & ctrl_q.regWrite;
   assign ctrl_io.ResultSrc = rst ? 2'b00 : ctrl_q.resultSrc;
   assign ctrl_io.ALUSrcA   = rst ? 2'b00 : ctrl_q.aluSrcA;
   assign ctrl_io.ALUSrcB   = rst ? 2'b00 : ctrl_q.aluSrcB;
   assign ctrl_io.ALUOp     = rst ? 2'b00 : ctrl_q.aluOp;
   assign ctrl_io.ImmSrc    = rst ? 3'b000 : immSrc;
   assign ctrl_io.illegal   = ~rst & ctrl_q.illegal;
   assign ctrl_io.state_o   = state_q;
   assign ctrl_io.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle control FSM: default build, a no-extension 4-bit counter
// build, and a handshake-free non-trapping build, each driven with hand-computed vectors.
module tb_multicycle_control_fsm;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   logic clk;
   logic rstA, rstB, rstC;
   int   compared;
   int   mismatched;

   multicycle_control_fsm_if #(.CNT_W(32)) ifA();
   multicycle_control_fsm_if #(.CNT_W(4))  ifB();
   multicycle_control_fsm_if #(.CNT_W(32)) ifC();

   multicycle_control_fsm #(.MEM_HANDSHAKE(1), .EXT_OPS(1), .TRAP_ILLEGAL(1), .CNT_W(32)) dutA (
      .clk(clk), .rst(rstA), .ctrl_io(ifA.master));
   multicycle_control_fsm #(.MEM_HANDSHAKE(1), .EXT_OPS(0), .TRAP_ILLEGAL(1), .CNT_W(4)) dutB (
      .clk(clk), .rst(rstB), .ctrl_io(ifB.master));
   multicycle_control_fsm #(.MEM_HANDSHAKE(0), .EXT_OPS(1), .TRAP_ILLEGAL(0), .CNT_W(32)) dutC (
      .clk(clk), .rst(rstC), .ctrl_io(ifC.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control vector: {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,A,B,ALUOp,ImmSrc,illegal}
   function automatic logic [16:0] ctl(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] alu, input logic [2:0] imm,
                                       input logic ill);
      return {pcw, adr, irw, mw, rw, res, a, b, alu, imm, ill};
   endfunction

   function automatic logic [16:0] obsA();
      return {ifA.PCWrite, ifA.AdrSrc, ifA.IRWrite, ifA.MemWrite, ifA.RegWrite, ifA.ResultSrc,
              ifA.ALUSrcA, ifA.ALUSrcB, ifA.ALUOp, ifA.ImmSrc, ifA.illegal};
   endfunction

   function automatic logic [16:0] obsC();
      return {ifC.PCWrite, ifC.AdrSrc, ifC.IRWrite, ifC.MemWrite, ifC.RegWrite, ifC.ResultSrc,
              ifC.ALUSrcA, ifC.ALUSrcB, ifC.ALUOp, ifC.ImmSrc, ifC.illegal};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic zero, input logic ready);
      ifA.op = op;
      ifA.zero = zero;
      ifA.mem_ready = ready;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rstA = 1'b1;
      rstB = 1'b1;
      rstC = 1'b1;
      ifB.op = OP_RTYPE; ifB.zero = 1'b0; ifB.mem_ready = 1'b1;
      ifC.op = OP_RTYPE; ifC.zero = 1'b0; ifC.mem_ready = 1'b1;

      // Reset holds everything quiet, even the op-driven ImmSrc and branch PCWrite.
      applyStimulus(OP_JAL, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("rst_outputs", 32'(obsA()), 32'(ctl(0,0,0,0,0,0,0,0,0,0,0)));
      checkOutput("rst_state", 32'(ifA.state_o), 32'd0);
      checkOutput("rst_instret", ifA.instret, 32'd0);

      // R-type walk: 0,1,6,8,0.
      rstA = 1'b0;
      applyStimulus(OP_RTYPE, 1'b0, 1'b1);
      checkOutput("r_fetch", 32'(obsA()), 32'(ctl(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));
      checkOutput("r_fetch_state", 32'(ifA.state_o), 32'd0);
      tick();
      checkOutput("r_decode", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0)));
      checkOutput("r_decode_state", 32'(ifA.state_o), 32'd1);
      tick();
      checkOutput("r_execr", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0)));
      checkOutput("r_execr_state", 32'(ifA.state_o), 32'd6);
      tick();
      checkOutput("r_aluwb", 32'(obsA()), 32'(ctl(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0)));
      checkOutput("r_aluwb_state", 32'(ifA.state_o), 32'd8);
      checkOutput("r_instret_pre", ifA.instret, 32'd0);
      tick();
      checkOutput("r_back_state", 32'(ifA.state_o), 32'd0);
      checkOutput("r_instret", ifA.instret, 32'd1);

      // Load stalled three cycles in MEMREAD.
      applyStimulus(OP_LOAD, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("ld_memadr_state", 32'(ifA.state_o), 32'd2);
      applyStimulus(OP_LOAD, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("ld_wait%0d_state", i), 32'(ifA.state_o), 32'd3);
         checkOutput($sformatf("ld_wait%0d_out", i), 32'(obsA()),
                     32'(ctl(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0)));
         tick();
      end
      applyStimulus(OP_LOAD, 1'b0, 1'b1);
      checkOutput("ld_last_state", 32'(ifA.state_o), 32'd3);
      tick();
      checkOutput("ld_memwb_state", 32'(ifA.state_o), 32'd4);
      checkOutput("ld_memwb", 32'(obsA()), 32'(ctl(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0)));
      tick();
      checkOutput("ld_back_state", 32'(ifA.state_o), 32'd0);
      checkOutput("ld_regwrite_off", 32'(ifA.RegWrite), 32'd0);
      checkOutput("ld_instret", ifA.instret, 32'd2);

      // Store: fetch stall suppresses IRWrite/PCWrite, MemWrite held across write waits.
      applyStimulus(OP_STORE, 1'b0, 1'b0);
      checkOutput("st_fetchwait", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0)));
      tick();
      checkOutput("st_fetchwait_state", 32'(ifA.state_o), 32'd0);
      applyStimulus(OP_STORE, 1'b0, 1'b1);
      checkOutput("st_fetch", 32'(obsA()), 32'(ctl(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0)));
      tick();
      tick();
      applyStimulus(OP_STORE, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("st_wait%0d_state", i), 32'(ifA.state_o), 32'd5);
         checkOutput($sformatf("st_wait%0d_out", i), 32'(obsA()),
                     32'(ctl(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b001,0)));
         tick();
      end
      applyStimulus(OP_STORE, 1'b0, 1'b1);
      checkOutput("st_last_memwrite", 32'(ifA.MemWrite), 32'd1);
      tick();
      checkOutput("st_back_state", 32'(ifA.state_o), 32'd0);
      checkOutput("st_instret", ifA.instret, 32'd3);

      // BEQ taken then not taken in the same state.
      applyStimulus(OP_BEQ, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("beq_state", 32'(ifA.state_o), 32'd9);
      checkOutput("beq_taken", 32'(obsA()), 32'(ctl(1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0)));
      applyStimulus(OP_BEQ, 1'b0, 1'b1);
      checkOutput("beq_nottaken", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0)));
      tick();
      checkOutput("beq_back_state", 32'(ifA.state_o), 32'd0);
      checkOutput("beq_instret", ifA.instret, 32'd4);

      // JAL: 0,1,10,8,0.
      applyStimulus(OP_JAL, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("jal_state", 32'(ifA.state_o), 32'd10);
      checkOutput("jal_out", 32'(obsA()), 32'(ctl(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b011,0)));
      tick();
      checkOutput("jal_wb_state", 32'(ifA.state_o), 32'd8);
      tick();
      checkOutput("jal_instret", ifA.instret, 32'd5);

      // LUI and AUIPC with extensions enabled.
      applyStimulus(OP_LUI, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("lui_state", 32'(ifA.state_o), 32'd11);
      checkOutput("lui_out", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b00,2'b00,2'b01,2'b11,3'b100,0)));
      tick();
      checkOutput("lui_wb_state", 32'(ifA.state_o), 32'd8);
      tick();
      applyStimulus(OP_AUIPC, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("auipc_state", 32'(ifA.state_o), 32'd12);
      checkOutput("auipc_out", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b100,0)));
      tick();
      tick();
      checkOutput("auipc_instret", ifA.instret, 32'd7);

      // Reset in the middle of a stalled MEMREAD.
      applyStimulus(OP_LOAD, 1'b0, 1'b1);
      tick();
      applyStimulus(OP_LOAD, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("mid_memread_state", 32'(ifA.state_o), 32'd3);
      rstA = 1'b1;
      #1;
      checkOutput("mid_rst_outputs", 32'(obsA()), 32'(ctl(0,0,0,0,0,0,0,0,0,0,0)));
      checkOutput("mid_rst_state", 32'(ifA.state_o), 32'd0);
      checkOutput("mid_rst_instret", ifA.instret, 32'd0);
      tick();
      rstA = 1'b0;
      applyStimulus(OP_LOAD, 1'b0, 1'b1);
      checkOutput("post_rst_fetch", 32'(obsA()), 32'(ctl(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));

      // Unknown opcode traps and stays put without retiring.
      applyStimulus(OP_BAD, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("trap_out", 32'(obsA()), 32'(ctl(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1)));
      tick();
      tick();
      checkOutput("trap_held_state", 32'(ifA.state_o), 32'd15);
      checkOutput("trap_instret", ifA.instret, 32'd0);
      rstA = 1'b1;

      // Without extensions LUI is illegal and parks.
      rstB = 1'b0;
      ifB.op = OP_LUI;
      #1;
      tick();
      tick();
      checkOutput("b_lui_state", 32'(ifB.state_o), 32'd15);
      checkOutput("b_lui_illegal", 32'(ifB.illegal), 32'd1);
      tick();
      checkOutput("b_lui_held", 32'(ifB.state_o), 32'd15);
      rstB = 1'b1;
      tick();
      rstB = 1'b0;
      ifB.op = OP_RTYPE;
      #1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         tick();
         tick();
         tick();
         checkOutput($sformatf("b_instret%0d", i), 32'(ifB.instret), 32'(i % 16));
      end
      rstB = 1'b1;

      // Handshake-free, non-trapping build.
      rstC = 1'b0;
      ifC.op = OP_STORE;
      ifC.mem_ready = 1'b0;
      #1;
      checkOutput("c_fetch_noready", 32'(obsC()), 32'(ctl(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0)));
      tick();
      tick();
      tick();
      checkOutput("c_store_state", 32'(ifC.state_o), 32'd5);
      checkOutput("c_store_out", 32'(obsC()), 32'(ctl(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b001,0)));
      tick();
      checkOutput("c_store_back", 32'(ifC.state_o), 32'd0);
      checkOutput("c_store_instret", ifC.instret, 32'd1);
      ifC.op = OP_BAD;
      #1;
      tick();
      tick();
      checkOutput("c_illegal_state", 32'(ifC.state_o), 32'd15);
      checkOutput("c_illegal_flag", 32'(ifC.illegal), 32'd1);
      tick();
      checkOutput("c_illegal_exit", 32'(ifC.state_o), 32'd0);
      checkOutput("c_illegal_instret", ifC.instret, 32'd1);
      rstC = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
